// File: rtl/dred_expander.sv
// Rebuilds an N-input Boolean function from K parity projections plus a 2^K-entry
// reduced table, fed per vector by handshake or by an internal full-range sweep.
module dred_expander #(
   parameter int N = 8,
   parameter int K = 4,
   localparam int KW = (K > 1) ? $clog2(K) : 1,
   localparam int TW = 1 << K
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          mask_we,
   input  logic [KW-1:0] mask_idx,
   input  logic [N-1:0]  mask_data,
   input  logic          tt_we,
   input  logic [TW-1:0] tt_data,
   output logic          cfg_err,
   input  logic          sweep_start,
   output logic          sweep_busy,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [N-1:0]  in_x,
   output logic          out_valid,
   input  logic          out_ready,
   output logic          out_y,
   output logic [N-1:0]  out_x,
   output logic          out_last
);

   localparam logic [N:0] LAST_CNT = {1'b0, {N{1'b1}}};

   logic [N-1:0]    mask_q [K];
   logic [TW-1:0]   tt_q;
   logic            cfgErr_q, cfgErr_d;
   logic            busy_q, busy_d;
   logic [N:0]      cnt_q, cnt_d;

   logic            s1Valid_q, s1Last_q;
   logic [N-1:0]    s1X_q;
   logic [K-1:0]    s1Z_q;
   logic            s2Valid_q, s2Y_q, s2Last_q;
   logic [N-1:0]    s2X_q;

   logic            s1Adv, s2Adv, accept, srcLast, cfgIdle, idxOk;
   logic            maskWrOk, ttWrOk;
   logic [N-1:0]    srcX;
   logic [K-1:0]    srcZ;
   logic [(1<<KW)-1:0] idxValid;

   // Stall chain, source selection and projection of the selected vector
   always_comb begin
      s2Adv   = !s2Valid_q || out_ready;
      s1Adv   = !s1Valid_q || s2Adv;
      accept  = s1Adv && (busy_q || (in_valid && !sweep_start));
      srcX    = busy_q ? cnt_q[N-1:0] : in_x;
      srcLast = busy_q && (cnt_q == LAST_CNT);
      srcZ    = '0;
      for (int j = 0; j < K; j++) begin
         srcZ[j] = ^(srcX & mask_q[j]);
      end
   end

   // A same-cycle sweep_start claims the source, so the handshake is refused
   assign in_ready = s1Adv && !busy_q && !sweep_start;

   // Config writes land only on a fully drained, non-sweeping block
   always_comb begin
      idxValid = '0;
      for (int i = 0; i < (1 << KW); i++) begin
         idxValid[i] = (i < K);
      end
      cfgIdle  = !busy_q && !s1Valid_q && !s2Valid_q;
      idxOk    = idxValid[mask_idx];
      maskWrOk = mask_we && cfgIdle && idxOk;
      ttWrOk   = tt_we && cfgIdle;
      cfgErr_d = (mask_we && (!cfgIdle || !idxOk)) || (tt_we && !cfgIdle);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int j = 0; j < K; j++) begin
            mask_q[j] <= N'(1) << j;
         end
         tt_q     <= '0;
         cfgErr_q <= 1'b0;
      end else begin
         for (int j = 0; j < K; j++) begin
            if (maskWrOk && (mask_idx == KW'(j))) begin
               mask_q[j] <= mask_data;
            end
         end
         if (ttWrOk) begin
            tt_q <= tt_data;
         end
         cfgErr_q <= cfgErr_d;
      end
   end

   // Sweep counter is one bit wider than x so the terminal value is unambiguous
   always_comb begin
      busy_d = busy_q;
      cnt_d  = cnt_q;
      if (!busy_q) begin
         if (sweep_start) begin
            busy_d = 1'b1;
            cnt_d  = '0;
         end
      end else if (accept) begin
         cnt_d = cnt_q + 1'b1;
         if (srcLast) begin
            busy_d = 1'b0;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         busy_q <= 1'b0;
         cnt_q  <= '0;
      end else begin
         busy_q <= busy_d;
         cnt_q  <= cnt_d;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1Valid_q <= 1'b0;
         s1X_q     <= '0;
         s1Z_q     <= '0;
         s1Last_q  <= 1'b0;
      end else if (s1Adv) begin
         s1Valid_q <= accept;
         if (accept) begin
            s1X_q    <= srcX;
            s1Z_q    <= srcZ;
            s1Last_q <= srcLast;
         end
      end
   end

   // Table lookup stage; holds its contents while downstream stalls
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s2Valid_q <= 1'b0;
         s2Y_q     <= 1'b0;
         s2X_q     <= '0;
         s2Last_q  <= 1'b0;
      end else if (s2Adv) begin
         s2Valid_q <= s1Valid_q;
         if (s1Valid_q) begin
            s2Y_q    <= tt_q[s1Z_q];
            s2X_q    <= s1X_q;
            s2Last_q <= s1Last_q;
         end
      end
   end

   assign out_valid  = s2Valid_q;
   assign out_y      = s2Y_q;
   assign out_x      = s2X_q;
   assign out_last   = s2Last_q;
   assign sweep_busy = busy_q;
   assign cfg_err    = cfgErr_q;

endmodule

// File: tb/tb_dred_expander.sv
// Scoreboard bench for dred_expander: directed vectors push expected results,
// an independent monitor pops and compares every accepted output.
module tb_dred_expander;

   localparam int N = 8;
   localparam int K = 4;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic mask_we = 1'b0;
   logic [1:0] mask_idx = '0;
   logic [N-1:0] mask_data = '0;
   logic tt_we = 1'b0;
   logic [15:0] tt_data = '0;
   logic cfg_err, sweep_busy, in_ready, out_valid, out_y, out_last;
   logic sweep_start = 1'b0;
   logic in_valid = 1'b0;
   logic [N-1:0] in_x = '0;
   logic out_ready = 1'b1;
   logic [N-1:0] out_x;

   // Second instance with K=3 so an out-of-range mask index is expressible
   logic m2We = 1'b0;
   logic [1:0] m2Idx = '0;
   logic m2CfgErr, m2Busy, m2InReady, m2OutValid, m2OutY, m2OutLast;
   logic [N-1:0] m2OutX;

   typedef struct {
      logic [N-1:0] x;
      logic         y;
      logic         last;
      int           pres;
      bit           lat;
   } entry_t;

   entry_t sbQ[$];
   int cyc = 0;
   int passCnt = 0;
   int totalCnt = 0;
   int onesSeen = 0;

   dred_expander #(.N(N), .K(K)) dut (
      .clk(clk), .rst(rst), .mask_we(mask_we), .mask_idx(mask_idx),
      .mask_data(mask_data), .tt_we(tt_we), .tt_data(tt_data), .cfg_err(cfg_err),
      .sweep_start(sweep_start), .sweep_busy(sweep_busy), .in_valid(in_valid),
      .in_ready(in_ready), .in_x(in_x), .out_valid(out_valid), .out_ready(out_ready),
      .out_y(out_y), .out_x(out_x), .out_last(out_last)
   );

   dred_expander #(.N(N), .K(3)) dut2 (
      .clk(clk), .rst(rst), .mask_we(m2We), .mask_idx(m2Idx),
      .mask_data(8'h3C), .tt_we(1'b0), .tt_data(8'h00), .cfg_err(m2CfgErr),
      .sweep_start(1'b0), .sweep_busy(m2Busy), .in_valid(1'b0),
      .in_ready(m2InReady), .in_x(8'h00), .out_valid(m2OutValid), .out_ready(1'b1),
      .out_y(m2OutY), .out_x(m2OutX), .out_last(m2OutLast)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      totalCnt++;
      if (act === exp) passCnt++;
      else $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
   endtask

   // Monitor: every output transfer must match the head of the scoreboard
   always @(negedge clk) begin
      if (!rst && out_valid && out_ready) begin
         if (out_y) onesSeen++;
         if (sbQ.size() == 0) begin
            checkOutput("unexpected_out_x", 32'(out_x), 32'hFFFF_FFFF);
         end else begin
            entry_t e;
            e = sbQ.pop_front();
            checkOutput("out_x", 32'(out_x), 32'(e.x));
            checkOutput("out_y", 32'(out_y), 32'(e.y));
            checkOutput("out_last", 32'(out_last), 32'(e.last));
            if (e.lat) checkOutput("latency", 32'(cyc - e.pres), 32'd2);
         end
      end
   end

   task automatic pushExp(input logic [N-1:0] x, input logic y, input logic last, input int pres, input bit lat);
      entry_t e;
      e.x = x; e.y = y; e.last = last; e.pres = pres; e.lat = lat;
      sbQ.push_back(e);
   endtask

   // All tasks start and end at posedge+#1
   task automatic applyStimulus(input logic [N-1:0] x, input logic y, input bit lat);
      bit done;
      done = 1'b0;
      in_valid = 1'b1;
      in_x = x;
      for (int t = 0; t < 50 && !done; t++) begin
         @(negedge clk);
         if (in_ready) begin
            pushExp(x, y, 1'b0, cyc, lat);
            done = 1'b1;
         end
         @(posedge clk); #1;
      end
      if (!done) checkOutput("send_timeout", 32'd0, 32'd1);
   endtask

   task automatic waitDrain();
      for (int t = 0; t < 100 && sbQ.size() > 0; t++) begin
         @(posedge clk); #1;
      end
      checkOutput("drain", 32'(sbQ.size()), 32'd0);
   endtask

   task automatic writeMask(input logic [1:0] idx, input logic [N-1:0] data);
      mask_we = 1'b1; mask_idx = idx; mask_data = data;
      @(posedge clk); #1;
      mask_we = 1'b0;
      @(negedge clk);
      checkOutput("cfg_err_ok_mask", 32'(cfg_err), 32'd0);
      @(posedge clk); #1;
   endtask

   task automatic writeTT(input logic [15:0] data);
      tt_we = 1'b1; tt_data = data;
      @(posedge clk); #1;
      tt_we = 1'b0;
      @(negedge clk);
      checkOutput("cfg_err_ok_tt", 32'(cfg_err), 32'd0);
      @(posedge clk); #1;
   endtask

   // Expected sweep function with M0=0xC0, M1=0x01, M2=M3=0, T=0x0002
   task automatic runSweep(input bit with55, input bit doGuard);
      bit rdyBad;
      int onesBefore;
      int n;
      logic [N-1:0] xv;
      onesBefore = onesSeen;
      rdyBad = 1'b0;
      for (int i = 0; i < 256; i++) begin
         xv = N'(i);
         pushExp(xv, (xv[7] ^ xv[6]) & ~xv[0], (i == 255), 0, 1'b0);
      end
      sweep_start = 1'b1;
      if (with55) begin in_valid = 1'b1; in_x = 8'h55; end
      @(negedge clk);
      if (with55) checkOutput("simul_in_ready", 32'(in_ready), 32'd0);
      @(posedge clk); #1;
      sweep_start = 1'b0;
      in_valid = 1'b0;
      n = 0;
      while (sbQ.size() > 0 && n < 2000) begin
         @(negedge clk);
         if (sweep_busy && in_ready) rdyBad = 1'b1;
         if (doGuard && n == 10) checkOutput("guard_busy", 32'(sweep_busy), 32'd1);
         if (doGuard && n == 12) checkOutput("guard_tt_err_pulse", 32'(cfg_err), 32'd1);
         if (doGuard && n == 13) checkOutput("guard_tt_err_clear", 32'(cfg_err), 32'd0);
         if (doGuard && n == 22) checkOutput("guard_mask_err_pulse", 32'(cfg_err), 32'd1);
         @(posedge clk); #1;
         tt_we = doGuard && (n == 10);
         tt_data = 16'hFFFF;
         mask_we = doGuard && (n == 20);
         mask_idx = 2'd0;
         mask_data = 8'hFF;
         n++;
      end
      tt_we = 1'b0;
      mask_we = 1'b0;
      checkOutput("sweep_drain", 32'(sbQ.size()), 32'd0);
      checkOutput("sweep_in_ready_low", 32'(rdyBad), 32'd0);
      checkOutput("sweep_ones", 32'(onesSeen - onesBefore), 32'd64);
      checkOutput("sweep_busy_clear", 32'(sweep_busy), 32'd0);
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got timeout, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int bpIdx;
      bit stalled;
      logic [N-1:0] bpX [4];
      logic bpY [4];
      bpX = '{8'h00, 8'h40, 8'h80, 8'hC0};
      bpY = '{1'b0, 1'b1, 1'b1, 1'b0};

      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
      checkOutput("rst_out_x", 32'(out_x), 32'd0);
      checkOutput("rst_out_y", 32'(out_y), 32'd0);
      checkOutput("rst_out_last", 32'(out_last), 32'd0);
      checkOutput("rst_cfg_err", 32'(cfg_err), 32'd0);
      checkOutput("rst_sweep_busy", 32'(sweep_busy), 32'd0);
      checkOutput("rst_in_ready", 32'(in_ready), 32'd1);
      @(posedge clk); #1;

      // Reset while a stalled sweep has both stages full
      out_ready = 1'b0;
      sweep_start = 1'b1;
      @(posedge clk); #1;
      sweep_start = 1'b0;
      repeat (4) @(posedge clk);
      @(negedge clk);
      checkOutput("pre_rst_busy", 32'(sweep_busy), 32'd1);
      checkOutput("pre_rst_out_valid", 32'(out_valid), 32'd1);
      #2 rst = 1'b1;
      #1;
      checkOutput("async_rst_out_valid", 32'(out_valid), 32'd0);
      checkOutput("async_rst_busy", 32'(sweep_busy), 32'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      out_ready = 1'b1;
      stalled = 1'b0;
      repeat (5) begin
         @(negedge clk);
         if (out_valid) stalled = 1'b1;
      end
      checkOutput("post_rst_no_output", 32'(stalled), 32'd0);
      @(posedge clk); #1;

      // Default config: M0 one-hot, T all zero
      applyStimulus(8'hFF, 1'b0, 1'b1);
      in_valid = 1'b0;
      waitDrain();

      writeMask(2'd0, 8'hC0);
      writeTT(16'hAAAA);
      applyStimulus(8'h40, 1'b1, 1'b1);
      in_valid = 1'b0;
      waitDrain();
      applyStimulus(8'hC0, 1'b0, 1'b1);
      in_valid = 1'b0;
      waitDrain();

      // Backpressure: five cycles of out_ready low while streaming
      out_ready = 1'b0;
      bpIdx = 0;
      in_valid = 1'b1;
      in_x = bpX[0];
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         if (in_ready) begin pushExp(bpX[bpIdx], bpY[bpIdx], 1'b0, 0, 1'b0); bpIdx++; end
         if (out_valid) begin
            checkOutput("bp_hold_x", 32'(out_x), 32'h00);
            checkOutput("bp_hold_y", 32'(out_y), 32'd0);
         end
         @(posedge clk); #1;
         if (bpIdx < 4) in_x = bpX[bpIdx]; else in_valid = 1'b0;
      end
      checkOutput("bp_accepts_during_stall", 32'(bpIdx), 32'd2);
      out_ready = 1'b1;
      for (int c = 0; c < 50 && bpIdx < 4; c++) begin
         @(negedge clk);
         if (in_ready) begin pushExp(bpX[bpIdx], bpY[bpIdx], 1'b0, 0, 1'b0); bpIdx++; end
         @(posedge clk); #1;
         if (bpIdx < 4) in_x = bpX[bpIdx]; else in_valid = 1'b0;
      end
      in_valid = 1'b0;
      checkOutput("bp_all_sent", 32'(bpIdx), 32'd4);
      waitDrain();

      writeMask(2'd1, 8'h01);
      writeMask(2'd2, 8'h00);
      writeMask(2'd3, 8'h00);
      writeTT(16'h0002);
      runSweep(1'b0, 1'b1);
      runSweep(1'b1, 1'b0);

      // Out-of-range index on the K=3 instance, then a legal one
      m2Idx = 2'd3; m2We = 1'b1;
      @(posedge clk); #1;
      m2We = 1'b0;
      @(negedge clk);
      checkOutput("idx_range_err_pulse", 32'(m2CfgErr), 32'd1);
      @(negedge clk);
      checkOutput("idx_range_err_clear", 32'(m2CfgErr), 32'd0);
      @(posedge clk); #1;
      m2Idx = 2'd2; m2We = 1'b1;
      @(posedge clk); #1;
      m2We = 1'b0;
      @(negedge clk);
      checkOutput("idx_legal_no_err", 32'(m2CfgErr), 32'd0);

      $display("%0d/%0d checks passed", passCnt, totalCnt);
      $finish;
   end

endmodule
